// File: rtl/ofm_requant_packer.sv
// Requantises signed accumulators (bias, round-shift, ReLU, saturate) and packs
// 16 results per AXI word for the OFM FIFO, zero-padding the final partial word.
module ofm_requant_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int AXI_WIDTH  = 256,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  total_pixels,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_acc,
  input  logic [DATA_WIDTH-1:0] in_bias,
  input  logic                  ofm_ready,
  output logic                  write,
  output logic [AXI_WIDTH-1:0]  WDATA_OUT,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic                  busy,
  output logic                  done
);
  localparam int LANES = AXI_WIDTH / DATA_WIDTH;
  localparam int IDX_W = $clog2(LANES);
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam int RND_W = ACC_WIDTH + 2;
  localparam logic signed [RND_W-1:0] SAT_MAX =
    {{(RND_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN =
    {{(RND_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]     total_q, accepted_q, words_q;
  logic [4:0]               shift_q;
  logic                     relu_q;
  logic                     s1_valid_q, s2_valid_q;
  logic signed [SUM_W-1:0]  s1_sum_q;
  logic [DATA_WIDTH-1:0]    s2_pix_q;
  logic [AXI_WIDTH-1:0]     lanes_q, wdata_q;
  logic [IDX_W-1:0]         lane_idx_q;
  logic                     complete_q, pending_q, write_q;

  logic                     accept, flush_load, word_load;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [RND_W-1:0]  rnd, biased, shifted;
  logic [DATA_WIDTH-1:0]    pix_d;
  logic [AXI_WIDTH-1:0]     flush_word, word_src;

  assign sum_d = $signed({in_acc[ACC_WIDTH-1], in_acc})
               + $signed({{(SUM_W-DATA_WIDTH){in_bias[DATA_WIDTH-1]}}, in_bias});

  // Round half toward +inf, then floor-shift; 34 bits cannot overflow here.
  always_comb begin
    rnd = '0;
    if (shift_q != '0) rnd = RND_W'(1) << (shift_q - 5'd1);
    biased  = $signed({s1_sum_q[SUM_W-1], s1_sum_q}) + rnd;
    shifted = biased >>> shift_q;
    if (relu_q && shifted[RND_W-1]) shifted = '0;
    pix_d = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      pix_d = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) pix_d = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_comb begin
    flush_word = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k < 32'(lane_idx_q))
        flush_word[k*DATA_WIDTH +: DATA_WIDTH] = lanes_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    flush_load = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = !pending_q && ofm_ready && (accepted_q < total_q);
        if ((accepted_q == total_q) && !s1_valid_q && !s2_valid_q &&
            !complete_q && !pending_q)
          state_d = FLUSH;
      end
      // Partial word is loaded once (lane index cleared), then wait for it to drain.
      FLUSH: begin
        busy = 1'b1;
        if (lane_idx_q != '0) flush_load = !pending_q;
        else if (!pending_q && !write_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign word_load = complete_q || flush_load;
  assign word_src  = complete_q ? lanes_q : flush_word;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      total_q    <= '0;
      accepted_q <= '0;
      words_q    <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s2_pix_q   <= '0;
      lanes_q    <= '0;
      wdata_q    <= '0;
      lane_idx_q <= '0;
      complete_q <= 1'b0;
      pending_q  <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        total_q    <= (total_pixels == '0) ? CNT_WIDTH'(1) : total_pixels;
        shift_q    <= shift;
        relu_q     <= relu_en;
        accepted_q <= '0;
        lane_idx_q <= '0;
        words_q    <= '0;
      end
      if (accept) begin
        accepted_q <= accepted_q + 1'b1;
        s1_sum_q   <= sum_d;
      end
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      s2_pix_q   <= pix_d;

      complete_q <= 1'b0;
      if (s2_valid_q) begin
        lanes_q[32'(lane_idx_q)*DATA_WIDTH +: DATA_WIDTH] <= s2_pix_q;
        lane_idx_q <= lane_idx_q + 1'b1;
        if (lane_idx_q == LAST_LANE) complete_q <= 1'b1;
      end
      if (flush_load) lane_idx_q <= '0;

      write_q <= 1'b0;
      if (word_load) begin
        wdata_q <= word_src;
        if (ofm_ready) begin
          write_q <= 1'b1;
          words_q <= words_q + 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end else if (pending_q && ofm_ready) begin
        write_q   <= 1'b1;
        pending_q <= 1'b0;
        words_q   <= words_q + 1'b1;
      end
    end
  end

  assign write         = write_q;
  assign WDATA_OUT     = wdata_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_ofm_requant_packer.sv
// Directed bench for ofm_requant_packer: arithmetic, packing, flush, backpressure, reset abort.
module tb_ofm_requant_packer;
  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         start;
  logic [19:0]  total_pixels;
  logic [4:0]   shift;
  logic         relu_en;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_acc;
  logic [15:0]  in_bias;
  logic         ofm_ready;
  logic         write;
  logic [255:0] WDATA_OUT;
  logic [19:0]  words_written;
  logic         busy;
  logic         done;

  ofm_requant_packer #(.DATA_WIDTH(16), .AXI_WIDTH(256), .ACC_WIDTH(32), .CNT_WIDTH(20)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .total_pixels(total_pixels),
    .shift(shift), .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_bias(in_bias), .ofm_ready(ofm_ready), .write(write),
    .WDATA_OUT(WDATA_OUT), .words_written(words_written), .busy(busy), .done(done)
  );

  always #5 ACLK = ~ACLK;

  int cycle = 0;
  always @(posedge ACLK) cycle <= cycle + 1;

  int pass_cnt = 0;
  int tot = 0;
  int ir_viol = 0;
  int win_end = 0;
  logic [31:0]  acc_a [64];
  logic [15:0]  bias_a[64];
  logic [255:0] wq[$];
  int           wc[$];
  int           dc[$];
  logic [19:0]  ww_at_done;

  always @(negedge ACLK) begin
    if (write) begin
      wq.push_back(WDATA_OUT);
      wc.push_back(cycle);
    end
    if (done) begin
      dc.push_back(cycle);
      ww_at_done = words_written;
    end
  end

  task automatic clear_log();
    wq.delete(); wc.delete(); dc.delete();
    ir_viol = 0;
  endtask

  task automatic run_layer(input int n_total, input int n_feed, input int sh, input bit relu,
                           input int lo_start, input int lo_len, input bit wait_done);
    int i, cyc, d0;
    bit acc_now;
    i = 0; cyc = 0; d0 = dc.size();
    @(negedge ACLK);
    start = 1'b1; total_pixels = 20'(n_total); shift = 5'(sh); relu_en = relu;
    @(negedge ACLK);
    start = 1'b0;
    while (i < n_feed && cyc < 1000) begin
      ofm_ready = !(cyc >= lo_start && cyc < lo_start + lo_len);
      if (cyc == lo_start + lo_len) win_end = cycle;
      in_valid = 1'b1; in_acc = acc_a[i]; in_bias = bias_a[i];
      #1;
      acc_now = in_ready;
      if (!ofm_ready && in_ready) ir_viol++;
      @(negedge ACLK);
      if (acc_now) i++;
      cyc++;
    end
    in_valid = 1'b0; ofm_ready = 1'b1;
    tot++; if (i != n_feed) $display("FAIL feed: fed %0d expected %0d", i, n_feed); else pass_cnt++;
    if (wait_done) begin
      cyc = 0;
      while (dc.size() == d0 && cyc < 300) begin
        @(negedge ACLK);
        cyc++;
      end
      tot++; if (dc.size() == d0) $display("FAIL done_timeout: got none expected done pulse"); else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; start = 1'b1; total_pixels = 20'd16; shift = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_acc = '0; in_bias = '0; ofm_ready = 1'b1;
    repeat (3) @(negedge ACLK);
    tot++; if (write !== 1'b0) $display("FAIL rst_write: got %b expected 0", write); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    tot++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else pass_cnt++;
    tot++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    tot++; if (words_written !== 20'd0) $display("FAIL rst_words: got %0d expected 0", words_written); else pass_cnt++;
    tot++; if (WDATA_OUT !== 256'd0) $display("FAIL rst_wdata: got %h expected 0", WDATA_OUT); else pass_cnt++;
    start = 1'b0;
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK);
    tot++; if (busy !== 1'b0) $display("FAIL start_during_reset_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_arith();
    logic [15:0] exp_l[16];
    logic [15:0] got;
    exp_l = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h8000, 16'h7FFF,
              16'h0080, 16'h0090, 16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0, 16'h00E0, 16'h00F0};
    acc_a[0] = 32'h18; acc_a[1] = -32'sh18; acc_a[2] = 32'h7FFFFFFF; acc_a[3] = 32'h80000000;
    acc_a[4] = 32'h7;  acc_a[5] = 32'h8;    acc_a[6] = -32'sh100000; acc_a[7] = 32'h7FFF8;
    for (int j = 8; j < 16; j++) acc_a[j] = 32'(j * 256);
    for (int j = 0; j < 16; j++) bias_a[j] = '0;
    clear_log();
    run_layer(16, 16, 4, 1'b0, 999, 0, 1'b1);
    tot++; if (wq.size() != 1) $display("FAIL arith_writes: got %0d expected 1", wq.size()); else pass_cnt++;
    if (wq.size() >= 1) begin
      for (int j = 0; j < 16; j++) begin
        got = wq[0][j*16 +: 16];
        tot++; if (got !== exp_l[j]) $display("FAIL arith_lane%0d: got %h expected %h", j, got, exp_l[j]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_relu_bias();
    logic [255:0] e;
    acc_a[0] = 32'd3;  bias_a[0] = -16'sd5;
    acc_a[1] = 32'd10; bias_a[1] = -16'sd5;
    acc_a[2] = 32'h7FFFFFFF; bias_a[2] = 16'h7FFF;
    e = '0; e[31:16] = 16'h0005; e[47:32] = 16'h7FFF;
    clear_log();
    run_layer(3, 3, 0, 1'b1, 999, 0, 1'b1);
    tot++; if (wq.size() != 1) $display("FAIL relu_writes: got %0d expected 1", wq.size()); else pass_cnt++;
    if (wq.size() >= 1) begin
      tot++; if (wq[0] !== e) $display("FAIL relu_word: got %h expected %h", wq[0], e); else pass_cnt++;
    end
  endtask

  task automatic check_words(input int n, input int nwords, input int base, input string tag);
    logic [255:0] e;
    for (int w = 0; w < nwords && w < wq.size(); w++) begin
      e = '0;
      for (int j = 0; j < 16; j++)
        if (w * 16 + j < n) e[j*16 +: 16] = 16'(base + w * 16 + j);
      tot++; if (wq[w] !== e) $display("FAIL %s_word%0d: got %h expected %h", tag, w, wq[w], e); else pass_cnt++;
    end
  endtask

  task automatic test_full_words();
    for (int j = 0; j < 64; j++) begin acc_a[j] = 32'(j + 1); bias_a[j] = '0; end
    clear_log();
    run_layer(32, 32, 0, 1'b0, 999, 0, 1'b1);
    tot++; if (wq.size() != 2) $display("FAIL full_writes: got %0d expected 2", wq.size()); else pass_cnt++;
    check_words(32, 2, 1, "full");
    if (wc.size() == 2) begin
      tot++; if (wc[1] - wc[0] != 16) $display("FAIL full_spacing: got %0d expected 16", wc[1] - wc[0]); else pass_cnt++;
      if (dc.size() >= 1) begin
        tot++; if (dc[0] - wc[1] != 2) $display("FAIL full_done_gap: got %0d expected 2", dc[0] - wc[1]); else pass_cnt++;
      end
    end
    tot++; if (dc.size() != 1) $display("FAIL full_done_count: got %0d expected 1", dc.size()); else pass_cnt++;
    tot++; if (ww_at_done !== 20'd2) $display("FAIL full_words_written: got %0d expected 2", ww_at_done); else pass_cnt++;
  endtask

  task automatic test_partial();
    clear_log();
    run_layer(20, 20, 0, 1'b0, 999, 0, 1'b1);
    tot++; if (wq.size() != 2) $display("FAIL partial_writes: got %0d expected 2", wq.size()); else pass_cnt++;
    check_words(20, 2, 1, "partial");
    tot++; if (ww_at_done !== 20'd2) $display("FAIL partial_words_written: got %0d expected 2", ww_at_done); else pass_cnt++;
    if (wc.size() == 2 && dc.size() >= 1) begin
      tot++; if (dc[0] - wc[1] != 2) $display("FAIL partial_done_gap: got %0d expected 2", dc[0] - wc[1]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    run_layer(48, 48, 0, 1'b0, 18, 10, 1'b1);
    tot++; if (wq.size() != 3) $display("FAIL bp_writes: got %0d expected 3", wq.size()); else pass_cnt++;
    check_words(48, 3, 1, "bp");
    if (wc.size() >= 1) begin
      tot++; if (wc[0] < win_end + 1) $display("FAIL bp_write_delay: got cycle %0d expected >= %0d", wc[0], win_end + 1); else pass_cnt++;
    end
    tot++; if (ir_viol != 0) $display("FAIL bp_in_ready: got %0d violations expected 0", ir_viol); else pass_cnt++;
    tot++; if (ww_at_done !== 20'd3) $display("FAIL bp_words_written: got %0d expected 3", ww_at_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    run_layer(16, 7, 0, 1'b0, 999, 0, 1'b0);
    ARESETN = 1'b0;
    #1;
    tot++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else pass_cnt++;
    tot++; if (WDATA_OUT !== 256'd0) $display("FAIL mid_rst_wdata: got %h expected 0", WDATA_OUT); else pass_cnt++;
    tot++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    repeat (4) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    tot++; if (wq.size() + dc.size() != 0) $display("FAIL mid_rst_no_output: got %0d events expected 0", wq.size() + dc.size()); else pass_cnt++;
    for (int j = 0; j < 16; j++) acc_a[j] = 32'h100 + 32'(j);
    run_layer(16, 16, 0, 1'b0, 999, 0, 1'b1);
    tot++; if (wq.size() != 1) $display("FAIL mid_rst_writes: got %0d expected 1", wq.size()); else pass_cnt++;
    check_words(16, 1, 16'h100, "mid_rst");
  endtask

  task automatic test_total_zero();
    logic [255:0] e;
    acc_a[0] = 32'h1234; bias_a[0] = '0;
    e = '0; e[15:0] = 16'h1234;
    clear_log();
    run_layer(0, 1, 0, 1'b0, 999, 0, 1'b1);
    tot++; if (wq.size() != 1) $display("FAIL zero_writes: got %0d expected 1", wq.size()); else pass_cnt++;
    if (wq.size() >= 1) begin
      tot++; if (wq[0] !== e) $display("FAIL zero_word: got %h expected %h", wq[0], e); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_relu_bias();
    test_full_words();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_total_zero();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ofm_requant_packer.md
Name: ofm_requant_packer

Overview:
- Sits directly upstream of the AXI master's OFM FIFO write port (WDATA_IN/write).
- Accepts one 32-bit signed convolution accumulator per cycle from the CNN engine and adds a per-filter bias.
- Rounds and shifts, applies optional ReLU, then saturates each result to 16 bits.
- Packs 16 results into one 256-bit word and emits a single-cycle write pulse; a partial final word is zero-padded at end of layer.

Parameters:
- DATA_WIDTH, 16, output pixel width.
- AXI_WIDTH, 256, packed word width; LANES = AXI_WIDTH/DATA_WIDTH = 16.
- ACC_WIDTH, 32, signed accumulator input width.
- CNT_WIDTH, 20, width of the pixel and word counters.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches total_pixels, shift and relu_en, then begins a layer.
- total_pixels  in  CNT_WIDTH  number of results in the layer; 0 is treated as 1.
- shift  in  5  arithmetic right-shift amount, 0..31.
- relu_en  in  1  clamp negative results to 0.
- in_valid  in  1  accumulator valid.
- in_ready  out  1  block accepts an accumulator this cycle.
- in_acc  in  ACC_WIDTH  signed accumulator.
- in_bias  in  DATA_WIDTH  signed bias, sampled together with in_acc.
- ofm_ready  in  1  OFM FIFO has space for at least one word.
- write  out  1  single-cycle word write strobe.
- WDATA_OUT  out  AXI_WIDTH  packed word; valid when write=1.
- words_written  out  CNT_WIDTH  count of words emitted in the current layer.
- busy  out  1  layer in progress.
- done  out  1  single-cycle pulse after the last word is emitted.

Behaviour:
- Reset: all outputs 0; state=IDLE; lanes, counters and the pending register cleared.
- State IDLE → RUN on start. Latch the configuration, then clear the accepted-pixel count, lane index and words_written. start while busy is ignored.
- State RUN: in_ready = !pending && ofm_ready && (accepted < total).
  - Accept occurs when in_valid && in_ready.
  - When accepted == total and the pipeline is empty, go to FLUSH.
- State FLUSH: if lane index ≠ 0, zero-fill lanes [idx..15] and emit the word (subject to pending rules). Then go to DONE.
- State DONE: done=1 for one cycle, busy=0, go to IDLE.
- busy=1 in RUN and FLUSH.
- Pipeline stage 1 (registered):
  - sum = sext33(in_acc) + sext33(in_bias).
- Pipeline stage 2 (registered):
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at 34 bits with no overflow.
  - If relu_en and r<0, r=0.
  - Saturate to [-32768, 32767].
- Input to lane write: 2 cycles, fixed; stages advance every cycle with no stall.
- Packing: pixel n of a word goes to WDATA bits [16n+15:16n], so the first pixel is in lane 0.
  - When lane 15 is written, the word is complete.
  - If ofm_ready=1 the next cycle drives write=1 with that word; otherwise it is held in the pending register.
- Pending word: write asserts on the first cycle ofm_ready=1. in_ready stays low while pending.
  - The at most 2 in-flight pixels continue into lanes 0–1 of the next word.
  - A second completion while pending is therefore impossible and needs no handling.
- words_written increments on every write, including the flushed partial word.
- Backpressure on in_valid: in_acc and in_bias are sampled only on accept.
- ofm_ready dropping mid-layer stops acceptance immediately; no data is lost.
- Simultaneous start and reset: reset wins.
- Reset mid-layer: immediate abort. No write or done is produced and partial data is discarded.
- total_pixels a multiple of 16: FLUSH emits nothing extra; done follows the last full-word write by 2 cycles.

Test Plan:
- Arithmetic: shift=4, relu_en=0, bias=0, 16 pixels with acc = 0x18, −0x18, 0x7FFFFFFF, −0x80000000, 0x7, 0x8 …
  - → lanes 0x0002, 0xFFFF (−1; rounding is toward +∞ at the half), 0x7FFF, 0x8000, 0x0000, 0x0001.
- ReLU and bias: relu_en=1, bias=−5, acc=3, shift=0 → lane 0x0000; acc=10 → 0x0005.
- Full words: total_pixels=32, in_valid held high, ofm_ready=1.
  - → exactly 2 write pulses, 16 cycles apart, with lane k = the k-th input.
  - → words_written=2 and done pulses once, 2 cycles after the second write.
- Partial flush: total_pixels=20.
  - → second word has lanes 0–3 = pixels 16–19 and lanes 4–15 = 0.
  - → words_written=2, then done.
- Backpressure: ofm_ready=0 at the 16th pixel for 10 cycles.
  - → write delayed until ofm_ready=1, in_ready low meanwhile.
  - → word content unchanged, no pixel lost or duplicated over 48 pixels.
- Reset mid-layer: ARESETN low after 7 pixels.
  - → all outputs 0 immediately.
  - → the next start with total_pixels=16 yields one word containing only the new data.
